// File: rtl/udp_ip_recv.sv
// udp_ip_recv: IPv4/UDP receive parser. Validates the IP and UDP headers of one
// packet per input frame, strips them, and streams the UDP payload out with sideband
// metadata. Optional macro UDP_RX_IPCSUM_EN enables IPv4 header checksum checking.
module udp_ip_recv #(
  parameter int unsigned CHECK_DST_IP = 1,
  parameter int unsigned ACCEPT_BCAST = 1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      local_IP_in,
  input  logic [31:0]      axis_tdata_in,
  input  logic             axis_tvalid_in,
  input  logic [3:0]       axis_tkeep_in,
  input  logic             axis_tlast_in,
  output logic             axis_tready_out,
  output logic [31:0]      udp_data_out,
  output logic             udp_valid_out,
  output logic [3:0]       udp_keep_out,
  output logic             udp_last_out,
  input  logic             udp_ready_in,
  output logic [31:0]      src_ip_out,
  output logic [15:0]      src_port_out,
  output logic [15:0]      dst_port_out,
  output logic [15:0]      payload_len_out,
  output logic             meta_valid_out,
  output logic             drop_pulse_out,
  output logic             err_trunc_out,
  output logic [CNT_W-1:0] good_cnt_out,
  output logic [CNT_W-1:0] drop_cnt_out
);

  // StPad discards trailing Ethernet padding without counting a drop.
  typedef enum logic [1:0] {StHdr, StDrop, StPayload, StPad} state_e;

  state_e      state_q, state_d;
  logic [2:0]  wcnt_q;
  logic        bad_q;
  logic [15:0] total_len_q;
  logic [31:0] src_ip_q;
  logic [31:0] ports_q;
  logic [15:0] rem_q;
  logic        trunc_q;

  logic        in_fire, out_fire;
  logic        dst_ok, word_bad, csum_bad;
  logic        hdr_last, hdr_good, short_evt, trunc_evt, drop_evt;
  logic [15:0] udp_len;
  logic [3:0]  last_keep;

  assign in_fire   = axis_tvalid_in && axis_tready_out;
  assign out_fire  = udp_valid_out && udp_ready_in;
  assign udp_len   = axis_tdata_in[31:16];
  assign hdr_last  = (state_q == StHdr) && in_fire && (wcnt_q == 3'd6);
  assign hdr_good  = hdr_last && !(bad_q || word_bad || csum_bad) && !axis_tlast_in;
  assign short_evt = (state_q == StHdr) && in_fire && (wcnt_q != 3'd6) && axis_tlast_in;
  assign trunc_evt = (state_q == StPayload) && in_fire && (rem_q > 16'd4) && axis_tlast_in;
  // A header that is good but ends on W6 carries no payload, so it is dropped too.
  assign drop_evt  = short_evt || (hdr_last && !hdr_good) || trunc_evt;

  // Destination address filter.
  always_comb begin
    dst_ok = 1'b1;
    if (CHECK_DST_IP != 0) begin
      dst_ok = (axis_tdata_in == local_IP_in) ||
               ((ACCEPT_BCAST != 0) && (axis_tdata_in == 32'hFFFF_FFFF));
    end
  end

  // Per-word header checks, folded into the sticky bad flag.
  always_comb begin
    word_bad = 1'b0;
    unique case (wcnt_q)
      3'd0:    word_bad = (axis_tdata_in[31:24] != 8'h45);
      3'd1:    word_bad = axis_tdata_in[13] || (axis_tdata_in[12:0] != 13'd0);
      3'd2:    word_bad = (axis_tdata_in[23:16] != 8'd17);
      3'd4:    word_bad = !dst_ok;
      3'd6:    word_bad = (udp_len <= 16'd8) ||
                          (({1'b0, udp_len} + 17'd20) > {1'b0, total_len_q});
      default: word_bad = 1'b0;
    endcase
  end

`ifdef UDP_RX_IPCSUM_EN
  logic [15:0] csum_q, csum_base, csum_mid, csum_new;
  logic [16:0] sum_a, sum_b;

  // One's-complement add of both halfwords of the current beat, end-around carry.
  always_comb begin
    csum_base = (wcnt_q == 3'd0) ? 16'h0000 : csum_q;
    sum_a     = {1'b0, csum_base} + {1'b0, axis_tdata_in[31:16]};
    csum_mid  = sum_a[15:0] + {15'd0, sum_a[16]};
    sum_b     = {1'b0, csum_mid} + {1'b0, axis_tdata_in[15:0]};
    csum_new  = sum_b[15:0] + {15'd0, sum_b[16]};
  end

  // Accumulate over W0..W4; the result is stable by the W6 decision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_q <= 16'h0000;
    end else if ((state_q == StHdr) && in_fire && (wcnt_q <= 3'd4)) begin
      csum_q <= csum_new;
    end
  end

  assign csum_bad = (csum_q != 16'hFFFF);
`else
  assign csum_bad = 1'b0;
`endif

  // Byte enables for the final payload beat.
  always_comb begin
    last_keep = 4'b1111;
    unique case (rem_q[2:0])
      3'd1:    last_keep = 4'b1000;
      3'd2:    last_keep = 4'b1100;
      3'd3:    last_keep = 4'b1110;
      default: last_keep = 4'b1111;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StHdr;
    else       state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHdr: begin
        if (hdr_good)                       state_d = StPayload;
        else if (hdr_last && !axis_tlast_in) state_d = StDrop;
      end
      StDrop, StPad: begin
        if (in_fire && axis_tlast_in) state_d = StHdr;
      end
      StPayload: begin
        if (in_fire) begin
          if (rem_q <= 16'd4)     state_d = axis_tlast_in ? StHdr : StPad;
          else if (axis_tlast_in) state_d = StHdr;
        end
      end
      default: state_d = StHdr;
    endcase
  end

  // FSM outputs: input ready. W6 is held off while the previous packet's output is
  // still pending so its metadata cannot be overwritten.
  always_comb begin
    axis_tready_out = 1'b1;
    unique case (state_q)
      StHdr:     axis_tready_out = !((wcnt_q == 3'd6) && meta_valid_out);
      StPayload: axis_tready_out = !udp_valid_out || udp_ready_in;
      default:   axis_tready_out = 1'b1;
    endcase
  end

  // Header capture, metadata, output stage and statistics.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt_q          <= 3'd0;
      bad_q           <= 1'b0;
      total_len_q     <= 16'd0;
      src_ip_q        <= 32'd0;
      ports_q         <= 32'd0;
      rem_q           <= 16'd0;
      trunc_q         <= 1'b0;
      udp_data_out    <= 32'd0;
      udp_valid_out   <= 1'b0;
      udp_keep_out    <= 4'd0;
      udp_last_out    <= 1'b0;
      src_ip_out      <= 32'd0;
      src_port_out    <= 16'd0;
      dst_port_out    <= 16'd0;
      payload_len_out <= 16'd0;
      meta_valid_out  <= 1'b0;
      drop_pulse_out  <= 1'b0;
      err_trunc_out   <= 1'b0;
      good_cnt_out    <= '0;
      drop_cnt_out    <= '0;
    end else begin
      drop_pulse_out <= drop_evt;
      err_trunc_out  <= trunc_evt;
      if (drop_evt) drop_cnt_out <= drop_cnt_out + CNT_W'(1);

      if ((state_q == StHdr) && in_fire) begin
        if ((wcnt_q == 3'd6) || axis_tlast_in) begin
          wcnt_q <= 3'd0;
          bad_q  <= 1'b0;
        end else begin
          wcnt_q <= wcnt_q + 3'd1;
          bad_q  <= bad_q || word_bad;
        end
        if (wcnt_q == 3'd0) total_len_q <= axis_tdata_in[15:0];
        if (wcnt_q == 3'd3) src_ip_q    <= axis_tdata_in;
        if (wcnt_q == 3'd5) ports_q     <= axis_tdata_in;
      end

      if (hdr_good) begin
        src_ip_out      <= src_ip_q;
        src_port_out    <= ports_q[31:16];
        dst_port_out    <= ports_q[15:0];
        payload_len_out <= udp_len - 16'd8;
        rem_q           <= udp_len - 16'd8;
        meta_valid_out  <= 1'b1;
        trunc_q         <= 1'b0;
      end

      if ((state_q == StPayload) && in_fire) begin
        udp_data_out  <= axis_tdata_in;
        udp_valid_out <= 1'b1;
        rem_q         <= rem_q - 16'd4;
        if (rem_q <= 16'd4) begin
          udp_last_out <= 1'b1;
          udp_keep_out <= last_keep;
        end else if (axis_tlast_in) begin
          udp_last_out <= 1'b1;
          udp_keep_out <= axis_tkeep_in;
          trunc_q      <= 1'b1;
        end else begin
          udp_last_out <= 1'b0;
          udp_keep_out <= 4'hF;
        end
      end else if (out_fire) begin
        udp_valid_out <= 1'b0;
        if (udp_last_out) begin
          meta_valid_out <= 1'b0;
          if (!trunc_q) good_cnt_out <= good_cnt_out + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_udp_ip_recv.sv
// Self-checking bench for udp_ip_recv: directed packets, expected payload beats kept in
// a scoreboard queue and compared as the DUT hands them off.
module tb_udp_ip_recv;

  localparam logic [31:0] LocalIp = 32'hC0A8_000A;
  localparam logic [31:0] SrcIp   = 32'h0A00_0001;
  localparam logic [15:0] SPort   = 16'h1234;
  localparam logic [15:0] DPort   = 16'h5678;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] local_IP_in;
  logic [31:0] axis_tdata_in;
  logic        axis_tvalid_in;
  logic [3:0]  axis_tkeep_in;
  logic        axis_tlast_in;
  logic        axis_tready_out;
  logic [31:0] udp_data_out;
  logic        udp_valid_out;
  logic [3:0]  udp_keep_out;
  logic        udp_last_out;
  logic        udp_ready_in;
  logic [31:0] src_ip_out;
  logic [15:0] src_port_out;
  logic [15:0] dst_port_out;
  logic [15:0] payload_len_out;
  logic        meta_valid_out;
  logic        drop_pulse_out;
  logic        err_trunc_out;
  logic [15:0] good_cnt_out;
  logic [15:0] drop_cnt_out;

  udp_ip_recv dut (
    .clk             (clk),
    .reset           (reset),
    .local_IP_in     (local_IP_in),
    .axis_tdata_in   (axis_tdata_in),
    .axis_tvalid_in  (axis_tvalid_in),
    .axis_tkeep_in   (axis_tkeep_in),
    .axis_tlast_in   (axis_tlast_in),
    .axis_tready_out (axis_tready_out),
    .udp_data_out    (udp_data_out),
    .udp_valid_out   (udp_valid_out),
    .udp_keep_out    (udp_keep_out),
    .udp_last_out    (udp_last_out),
    .udp_ready_in    (udp_ready_in),
    .src_ip_out      (src_ip_out),
    .src_port_out    (src_port_out),
    .dst_port_out    (dst_port_out),
    .payload_len_out (payload_len_out),
    .meta_valid_out  (meta_valid_out),
    .drop_pulse_out  (drop_pulse_out),
    .err_trunc_out   (err_trunc_out),
    .good_cnt_out    (good_cnt_out),
    .drop_cnt_out    (drop_cnt_out)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] pkt_q[$];
  beat_t       exp_q[$];
  logic [3:0]  pkt_last_keep;
  logic [79:0] exp_meta;
  logic [7:0]  pkt_id = 8'd0;
  logic        toggle_mode = 1'b0;
  int          beats_seen = 0, beats_exp = 0;
  int          n_drop = 0, n_trunc = 0, stalls = 0;
  int          exp_good = 0, exp_drop = 0, exp_trunc = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, apply new ready level just after posedge.
  task automatic tick(output logic acc);
    beat_t e;
    @(negedge clk);
    acc = axis_tvalid_in && axis_tready_out;
    if (axis_tvalid_in && !axis_tready_out) stalls++;
    if (drop_pulse_out) n_drop++;
    if (err_trunc_out) n_trunc++;
    if (udp_valid_out && udp_ready_in) begin
      beats_seen++;
      check("beat_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("beat", 128'({udp_data_out, udp_keep_out, udp_last_out}), 128'(e));
        check("meta", 128'({meta_valid_out, src_ip_out, src_port_out, dst_port_out,
                            payload_len_out}), 128'({1'b1, exp_meta}));
      end
    end
    @(posedge clk);
    #1;
    udp_ready_in = toggle_mode ? ~udp_ready_in : 1'b1;
  endtask

  function automatic logic [15:0] ip_csum(input logic [31:0] w0, w1, w2, w3, w4);
    logic [31:0] s;
    s = w0[31:16] + w0[15:0] + w1[31:16] + w1[15:0] + w2[31:16] + w2[15:0] +
        w3[31:16] + w3[15:0] + w4[31:16] + w4[15:0];
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
    return ~s[15:0];
  endfunction

  task automatic make_hdr(input logic [15:0] tot, input logic [7:0] proto,
                          input logic [15:0] frag, input logic [31:0] dst,
                          input logic [15:0] ulen, input logic [15:0] cxor);
    logic [31:0] w0, w1, w2;
    pkt_id = pkt_id + 8'd1;
    w0 = {8'h45, 8'h00, tot};
    w1 = {16'h1C46, frag};
    w2 = {8'd64, proto, 16'h0000};
    w2[15:0] = ip_csum(w0, w1, w2, SrcIp, dst) ^ cxor;
    pkt_q.push_back(w0);
    pkt_q.push_back(w1);
    pkt_q.push_back(w2);
    pkt_q.push_back(SrcIp);
    pkt_q.push_back(dst);
    pkt_q.push_back({SPort, DPort});
    pkt_q.push_back({ulen, 16'h0000});
    exp_meta = {SrcIp, SPort, DPort, ulen - 16'd8};
  endtask

  // nwords payload words go on the wire; the first nexp are expected at the output.
  task automatic add_payload(input int nwords, input int nexp, input logic [3:0] lastk);
    logic [31:0] w;
    beat_t       b;
    for (int i = 0; i < nwords; i++) begin
      w = {pkt_id, 8'(i), ~pkt_id, 8'(i) ^ 8'h5A};
      pkt_q.push_back(w);
      if (i < nexp) begin
        b.d = w;
        b.k = (i == nexp - 1) ? lastk : 4'hF;
        b.l = (i == nexp - 1);
        exp_q.push_back(b);
        beats_exp++;
      end
    end
  endtask

  task automatic send_pkt();
    logic acc;
    int   n;
    for (int i = 0; i < pkt_q.size(); i++) begin
      axis_tdata_in  = pkt_q[i];
      axis_tlast_in  = (i == pkt_q.size() - 1);
      axis_tkeep_in  = axis_tlast_in ? pkt_last_keep : 4'hF;
      axis_tvalid_in = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 200) begin
        tick(acc);
        n++;
      end
      if (!acc) begin
        check("in_accept", 128'(acc), 128'(1));
        break;
      end
    end
    axis_tvalid_in = 1'b0;
    axis_tlast_in  = 1'b0;
    pkt_q.delete();
  endtask

  task automatic drain_and_check(input string tag);
    logic acc;
    int   n = 0;
    while ((exp_q.size() != 0 || udp_valid_out) && n < 300) begin
      tick(acc);
      n++;
    end
    repeat (3) tick(acc);
    toggle_mode = 1'b0;
    check({tag, "_left"}, 128'(exp_q.size()), 128'(0));
    check({tag, "_beats"}, 128'(beats_seen), 128'(beats_exp));
    check({tag, "_good_cnt"}, 128'(good_cnt_out), 128'(exp_good));
    check({tag, "_drop_cnt"}, 128'(drop_cnt_out), 128'(exp_drop));
    check({tag, "_drop_pulses"}, 128'(n_drop), 128'(exp_drop));
    check({tag, "_trunc_pulses"}, 128'(n_trunc), 128'(exp_trunc));
  endtask

  initial begin
    reset          = 1'b1;
    local_IP_in    = LocalIp;
    axis_tdata_in  = '0;
    axis_tvalid_in = 1'b0;
    axis_tkeep_in  = '0;
    axis_tlast_in  = 1'b0;
    udp_ready_in   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out", 128'({udp_valid_out, udp_last_out, udp_keep_out, meta_valid_out,
                             drop_pulse_out, err_trunc_out, good_cnt_out, drop_cnt_out,
                             udp_data_out}), 128'(0));
    check("reset_meta", 128'({src_ip_out, src_port_out, dst_port_out, payload_len_out}),
          128'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", 128'(axis_tready_out), 128'(1));
    @(posedge clk);
    #1;

    // 1: 10-byte payload, frame 38 bytes.
    make_hdr(16'd38, 8'd17, 16'h0000, LocalIp, 16'd18, 16'h0000);
    add_payload(3, 3, 4'b1100);
    pkt_last_keep = 4'b1100;
    exp_good++;
    send_pkt();
    drain_and_check("t1_valid");

    // 2: TCP packet, 40 bytes; every beat must be taken without stalling.
    make_hdr(16'd40, 8'd6, 16'h0000, LocalIp, 16'd20, 16'h0000);
    add_payload(3, 0, 4'hF);
    pkt_last_keep = 4'hF;
    stalls = 0;
    exp_drop++;
    send_pkt();
    check("t2_stalls", 128'(stalls), 128'(0));
    drain_and_check("t2_tcp");

    // 3: 64-byte payload with output ready toggling every cycle.
    toggle_mode = 1'b1;
    make_hdr(16'd92, 8'd17, 16'h0000, LocalIp, 16'd72, 16'h0000);
    add_payload(16, 16, 4'hF);
    pkt_last_keep = 4'hF;
    exp_good++;
    send_pkt();
    drain_and_check("t3_backpressure");

    // 4: 6-byte payload followed by 20 bytes of Ethernet padding.
    make_hdr(16'd34, 8'd17, 16'h0000, LocalIp, 16'd14, 16'h0000);
    add_payload(7, 2, 4'b1100);
    pkt_last_keep = 4'b1100;
    exp_good++;
    send_pkt();
    drain_and_check("t4_padding");

    // 5: claims 40 payload bytes, frame ends after payload beat 2.
    make_hdr(16'd68, 8'd17, 16'h0000, LocalIp, 16'd48, 16'h0000);
    add_payload(2, 2, 4'b1110);
    pkt_last_keep = 4'b1110;
    exp_drop++;
    exp_trunc++;
    send_pkt();
    drain_and_check("t5_trunc");

    // 6: corrupted header checksum, then the correct one.
`ifdef UDP_RX_IPCSUM_EN
    make_hdr(16'd32, 8'd17, 16'h0000, LocalIp, 16'd12, 16'h0001);
    add_payload(1, 0, 4'hF);
    exp_drop++;
`else
    make_hdr(16'd32, 8'd17, 16'h0000, LocalIp, 16'd12, 16'h0001);
    add_payload(1, 1, 4'hF);
    exp_good++;
`endif
    pkt_last_keep = 4'hF;
    send_pkt();
    drain_and_check("t6_bad_csum");
    make_hdr(16'd32, 8'd17, 16'h0000, LocalIp, 16'd12, 16'h0000);
    add_payload(1, 1, 4'hF);
    pkt_last_keep = 4'hF;
    exp_good++;
    send_pkt();
    drain_and_check("t6_good_csum");

    // Header-rule drops: wrong dst, MF set, frag offset, UDP len 8, UDP len too big, short.
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: make_hdr(16'd32, 8'd17, 16'h0000, LocalIp + 32'd1, 16'd12, 16'h0000);
        1: make_hdr(16'd32, 8'd17, 16'h2000, LocalIp, 16'd12, 16'h0000);
        2: make_hdr(16'd32, 8'd17, 16'h0005, LocalIp, 16'd12, 16'h0000);
        3: make_hdr(16'd28, 8'd17, 16'h0000, LocalIp, 16'd8, 16'h0000);
        4: make_hdr(16'd32, 8'd17, 16'h0000, LocalIp, 16'd13, 16'h0000);
        default: make_hdr(16'd32, 8'd17, 16'h0000, LocalIp, 16'd12, 16'h0000);
      endcase
      if (k != 3) add_payload(1, 0, 4'hF);
      if (k == 5) begin
        while (pkt_q.size() > 4) void'(pkt_q.pop_back());
      end
      pkt_last_keep = 4'hF;
      exp_drop++;
      send_pkt();
      drain_and_check("hdr_drop");
    end

    // Limited broadcast destination is accepted; also proves the parser recovered.
    make_hdr(16'd33, 8'd17, 16'h0000, 32'hFFFF_FFFF, 16'd13, 16'h0000);
    add_payload(2, 2, 4'b1000);
    pkt_last_keep = 4'b1000;
    exp_good++;
    send_pkt();
    drain_and_check("bcast");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_ip_recv.md
Name: udp_ip_recv

Overview:
Receive-side counterpart of the UDP/IP transmit stack. Accepts a 32-bit AXI4-Stream carrying one IPv4 packet per frame, with the Ethernet header already stripped and the first beat equal to the first IP header word. It validates the IPv4 and UDP headers, strips both, and emits the UDP payload on a 32-bit AXIS with the source IP, source port, destination port and payload length as sideband metadata. It sits between the 8-to-32 receive width converter and the application.

Parameters:
- CHECK_DST_IP, 1: if 1, drop packets whose dst IP is neither local_IP_in nor (when ACCEPT_BCAST=1) 32'hFFFFFFFF.
- ACCEPT_BCAST, 1: accept the limited-broadcast dst IP.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  single clock; all logic in this domain.
- reset  in  1  asynchronous, active-high.
- local_IP_in  in  32  FPGA IP address; quasi-static.
- axis_tdata_in  in  32  big-endian; byte 0 in [31:24].
- axis_tvalid_in  in  1  input beat valid.
- axis_tkeep_in  in  4  keep[3] maps to [31:24]; MSB-contiguous.
- axis_tlast_in  in  1  last beat of the IP packet.
- axis_tready_out  out  1  input ready.
- udp_data_out  out  32  payload data.
- udp_valid_out  out  1  payload beat valid.
- udp_keep_out  out  4  payload byte enables.
- udp_last_out  out  1  last payload beat.
- udp_ready_in  in  1  application ready.
- src_ip_out  out  32  source IP of the current packet.
- src_port_out  out  16  UDP source port.
- dst_port_out  out  16  UDP destination port.
- payload_len_out  out  16  UDP length minus 8.
- meta_valid_out  out  1  metadata valid.
- drop_pulse_out  out  1  one-cycle pulse per dropped packet.
- err_trunc_out  out  1  one-cycle pulse on a truncated payload.
- good_cnt_out  out  CNT_W  count of packets delivered.
- drop_cnt_out  out  CNT_W  count of packets dropped.

Behaviour:
- Reset values: all outputs 0. State = HDR, word counter = 0, both counters = 0.
- Header word map:
  - W0: ver/IHL, TOS, total_len.
  - W1: ID, flags/frag offset.
  - W2: TTL, proto, header checksum.
  - W3: src IP.
  - W4: dst IP.
  - W5: src port, dst port.
  - W6: UDP length, UDP checksum.
  - W7 onward: payload.
- HDR state:
  - axis_tready_out = 1; fields latch on each accepted beat.
  - Failures are accumulated in a sticky bad flag. A packet fails if any of these hold:
    - version != 4 or IHL != 5;
    - proto != 17;
    - MF flag set or frag offset != 0;
    - dst IP check fails (per CHECK_DST_IP / ACCEPT_BCAST);
    - UDP length < 8 or UDP length > total_len - 20;
    - UDP length == 8 (empty payload).
  - Decision is taken on the cycle W6 is accepted:
    - bad: go to DROP, or straight back to HDR if W6 carried tlast.
    - good: go to PAYLOAD; src_ip_out, src_port_out, dst_port_out and payload_len_out register and meta_valid_out rises on the next cycle.
  - tlast before W6 means a short packet: drop, stay in HDR, counter reset.
- DROP state: axis_tready_out = 1, beats are discarded; return to HDR on tlast. Exactly one drop_pulse_out and one drop_cnt_out increment per dropped packet.
- PAYLOAD state:
  - Registered output stage, latency 1 cycle.
  - axis_tready_out = !udp_valid_out || udp_ready_in.
  - A remaining-bytes counter is loaded with payload_len and decrements by 4 per accepted beat.
  - On the beat where remaining <= 4:
    - udp_last_out = 1;
    - udp_keep_out = 4'b1000, 4'b1100, 4'b1110 or 4'b1111 for remaining = 1, 2, 3, 4.
  - Other beats use keep = 4'hF.
  - If that beat lacks tlast, the trailing padding goes to DROP-silent: discarded, no drop count.
- Early input tlast in PAYLOAD: emit that beat with udp_last_out = 1 and the input keep, pulse err_trunc_out, count as a drop (not good), return to HDR.
- meta_valid_out stays high and metadata stays stable from the first payload beat until the last beat handshakes. good_cnt_out increments on that handshake unless the packet was truncated.
- Output holds data/valid while udp_ready_in = 0. No beat is lost or duplicated.
- Counters wrap modulo 2^CNT_W.
- Reset mid-packet: immediate return to the reset state. The remainder of the in-flight input frame is parsed as a new header and is expected to fail and drop.

Optional Feature:
UDP_RX_IPCSUM_EN
- Defined: one's-complement sum of the 10 header halfwords (W0–W4), with end-around carry, must equal 16'hFFFF. Otherwise the bad flag is set and the packet is dropped. The check uses an accumulator that is updated per beat and resolves by the W6 decision.
- Not defined: the header checksum field is ignored and no accumulator logic is generated.

Test Plan:
1. Valid packet: dst = local_IP_in = 0xC0A8000A, sport 0x1234, dport 0x5678, UDP length 18 (10-byte payload) -> 3 beats out; last beat keep 4'b1100, udp_last_out = 1; metadata correct; good_cnt_out = 1.
2. Proto = 6 (TCP), total 40 bytes -> no udp_valid_out; one drop_pulse_out; drop_cnt_out = 1; all input beats accepted.
3. udp_ready_in toggled 0/1 every cycle over a 64-byte payload -> 16 beats in order, no loss or duplication, metadata stable throughout.
4. Payload 6 bytes plus 20 bytes of Ethernet pad before tlast -> 2 beats out (keep F, then 1100); padding discarded; good_cnt_out increments, drop_cnt_out does not.
5. tlast at payload beat 2 of a claimed 40-byte payload -> udp_last_out on beat 2; err_trunc_out pulse; drop_cnt_out + 1.
6. Define UDP_RX_IPCSUM_EN, corrupt header checksum by 1 -> packet dropped. Repeat with the correct checksum -> packet delivered.
